// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - two-way intersection phase controller with overflow watchdog
//
// Steps ALL_RED_A -> NS_GREEN -> NS_YELLOW -> ALL_RED_B -> EW_GREEN -> EW_YELLOW
// on each overflow pulse from the external phase counter and programs that
// counter's terminal count for the phase being entered. A watchdog forces a
// sticky FAULT state (left only through reset) if overflow stops arriving.
//
// Optional feature macro: TL_PED_WALK_EN (pedestrian request / walk lamp).
//
// Ports:
//   clk          in   1   single clock, rising edge
//   resetN       in   1   synchronous, active-high reset
//   overflow     in   1   one-cycle pulse from the phase counter
//   ped_request  in   1   pedestrian request (TL_PED_WALK_EN only)
//   walk         out  1   walk lamp, lit for a whole EW_GREEN (TL_PED_WALK_EN only)
//   max_count    out  11  terminal count for the phase counter (registered)
//   ns_light     out  3   north-south lamps, one-hot {red, yellow, green} (registered)
//   ew_light     out  3   east-west lamps, one-hot {red, yellow, green} (registered)
//   phase        out  3   current state code
//   fault        out  1   watchdog expired, sticky until reset

module traffic_phase_sequencer #(
    parameter int unsigned NS_GREEN_CYC = 200,
    parameter int unsigned EW_GREEN_CYC = 200,
    parameter int unsigned YELLOW_CYC   = 40,
    parameter int unsigned ALLRED_CYC   = 20,
    parameter int unsigned WDOG_CYC     = 2500
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        overflow,
`ifdef TL_PED_WALK_EN
    input  logic        ped_request,
    output logic        walk,
`endif
    output logic [10:0] max_count,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic [2:0]  phase,
    output logic        fault
);

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FAULT     = 3'd7
    } state_e;

    // The counter overflows when it reaches max_count, so each phase loads length - 1.
    localparam logic [10:0] NS_GREEN_MAX = 11'(NS_GREEN_CYC - 1);
    localparam logic [10:0] EW_GREEN_MAX = 11'(EW_GREEN_CYC - 1);
    localparam logic [10:0] YELLOW_MAX   = 11'(YELLOW_CYC - 1);
    localparam logic [10:0] ALLRED_MAX   = 11'(ALLRED_CYC - 1);
    localparam logic [11:0] WDOG_LAST    = 12'(WDOG_CYC - 1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    state_e      state_q, state_d;
    state_e      succ;
    logic        expired;
    logic [11:0] wdog_q, wdog_d;
    logic [10:0] max_count_q, max_count_d;
    logic [2:0]  ns_light_q, ns_light_d;
    logic [2:0]  ew_light_q, ew_light_d;
    logic        fault_q, fault_d;

    always_comb begin
        // Successor in the normal cycle; FAULT and the unused code 6 map to FAULT.
        succ = FAULT;
        case (state_q)
            ALL_RED_A: succ = NS_GREEN;
            NS_GREEN:  succ = NS_YELLOW;
            NS_YELLOW: succ = ALL_RED_B;
            ALL_RED_B: succ = EW_GREEN;
            EW_GREEN:  succ = EW_YELLOW;
            EW_YELLOW: succ = ALL_RED_A;
            default:   succ = FAULT;
        endcase

        // An overflow arriving on the expiry cycle still counts as progress.
        expired = (wdog_q == WDOG_LAST) && !overflow;

        state_d = state_q;
        if (succ == FAULT) begin
            state_d = FAULT;
        end else if (overflow) begin
            state_d = succ;
        end else if (expired) begin
            state_d = FAULT;
        end

        wdog_d = (overflow || (state_d != state_q)) ? 12'd0 : wdog_q + 12'd1;

        // Outputs are decoded from the state being entered so they change on
        // the same edge as the state itself.
        max_count_d = max_count_q;
        ns_light_d  = LAMP_RED;
        ew_light_d  = LAMP_RED;
        case (state_d)
            ALL_RED_A, ALL_RED_B: begin
                max_count_d = ALLRED_MAX;
            end
            NS_GREEN: begin
                max_count_d = NS_GREEN_MAX;
                ns_light_d  = LAMP_GRN;
            end
            NS_YELLOW: begin
                max_count_d = YELLOW_MAX;
                ns_light_d  = LAMP_YEL;
            end
            EW_GREEN: begin
                max_count_d = EW_GREEN_MAX;
                ew_light_d  = LAMP_GRN;
            end
            EW_YELLOW: begin
                max_count_d = YELLOW_MAX;
                ew_light_d  = LAMP_YEL;
            end
            default: begin
                // FAULT: flash-style yellow on both approaches, max_count frozen.
                ns_light_d = LAMP_YEL;
                ew_light_d = LAMP_YEL;
            end
        endcase

        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q     <= ALL_RED_A;
            wdog_q      <= 12'd0;
            max_count_q <= ALLRED_MAX;
            ns_light_q  <= LAMP_RED;
            ew_light_q  <= LAMP_RED;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            max_count_q <= max_count_d;
            ns_light_q  <= ns_light_d;
            ew_light_q  <= ew_light_d;
            fault_q     <= fault_d;
        end
    end

    assign max_count = max_count_q;
    assign ns_light  = ns_light_q;
    assign ew_light  = ew_light_q;
    assign phase     = state_q;
    assign fault     = fault_q;

`ifdef TL_PED_WALK_EN
    logic pending_q, pending_d;
    logic walk_q, walk_d;
    logic enter_ew;

    always_comb begin
        enter_ew = (state_d == EW_GREEN) && (state_q != EW_GREEN);
        // A request seen on the entry edge itself is served by this EW_GREEN;
        // anything later waits for the next one.
        pending_d = enter_ew ? 1'b0 : (pending_q | ped_request);
        if (enter_ew) begin
            walk_d = pending_q | ped_request;
        end else if (state_d == EW_GREEN) begin
            walk_d = walk_q;
        end else begin
            walk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            pending_q <= 1'b0;
            walk_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            walk_q    <= walk_d;
        end
    end

    assign walk = walk_q;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - self-checking bench for traffic_phase_sequencer with a phase counter model
module tb_traffic_phase_sequencer;

    localparam int NS_G  = 10;
    localparam int EW_G  = 8;
    localparam int YEL   = 4;
    localparam int ARED  = 3;
    localparam int WDOG  = 32;
    localparam int PERIOD = NS_G + EW_G + 2 * YEL + 2 * ARED;

    logic        clk = 1'b0;
    logic        resetN;
    logic        overflow;
    logic [10:0] max_count;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
    logic [2:0]  phase;
    logic        fault;
`ifdef TL_PED_WALK_EN
    logic        ped_request;
    logic        walk;
`endif

    int errors = 0;
    int checks = 0;

    // Phase counter: registered compare, so overflow appears the cycle after count == max_count.
    logic [10:0] cnt_q;
    logic        cnt_ovf_q;
    logic        ovf_sel;
    logic        ovf_force;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetN) begin
            cnt_q     <= 11'd0;
            cnt_ovf_q <= 1'b0;
        end else begin
            cnt_ovf_q <= (cnt_q == max_count);
            cnt_q     <= (cnt_q == max_count) ? 11'd0 : cnt_q + 11'd1;
        end
    end

    assign overflow = ovf_sel ? ovf_force : cnt_ovf_q;

    traffic_phase_sequencer #(
        .NS_GREEN_CYC(NS_G),
        .EW_GREEN_CYC(EW_G),
        .YELLOW_CYC  (YEL),
        .ALLRED_CYC  (ARED),
        .WDOG_CYC    (WDOG)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .overflow   (overflow),
`ifdef TL_PED_WALK_EN
        .ped_request(ped_request),
        .walk       (walk),
`endif
        .max_count  (max_count),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .phase      (phase),
        .fault      (fault)
    );

    // Reference model: current phase and cycles left in it, derived from the phase lengths.
    int m_ph;
    int m_rem;
`ifdef TL_PED_WALK_EN
    bit m_req;
    bit m_walk;
`endif

    function automatic int phase_len(input int p);
        case (p)
            1:       return NS_G;
            2, 5:    return YEL;
            4:       return EW_G;
            default: return ARED;
        endcase
    endfunction

    function automatic logic [2:0] exp_ns(input int p);
        if (p == 1) return 3'b001;
        if (p == 2 || p == 7) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] exp_ew(input int p);
        if (p == 4) return 3'b001;
        if (p == 5 || p == 7) return 3'b010;
        return 3'b100;
    endfunction

    task automatic model_reset();
        m_ph  = 0;
        m_rem = ARED + 1;   // the first ALL_RED_A includes the counter's start-up cycle
`ifdef TL_PED_WALK_EN
        m_req  = 0;
        m_walk = 0;
`endif
    endtask

    task automatic model_step();
        m_rem--;
        if (m_rem == 0) begin
            m_ph  = (m_ph == 5) ? 0 : m_ph + 1;
            m_rem = phase_len(m_ph);
        end
    endtask

`ifdef TL_PED_WALK_EN
    task automatic ped_model(input int prev_ph);
        if (m_ph != prev_ph) begin
            if (m_ph == 4) begin
                m_walk = m_req;
                m_req  = 0;
            end else begin
                m_walk = 0;
            end
        end
    endtask
`endif

    // Leaves the bench at the sample point of the first cycle after reset.
    task automatic apply_reset();
        @(negedge clk);
        resetN = 1'b1;
`ifdef TL_PED_WALK_EN
        ped_request = 1'b0;
`endif
        @(negedge clk);
        resetN = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        ovf_sel = 1'b0;
        ovf_force = 1'b0;
        apply_reset();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        checks++; if (max_count !== 11'd2) begin errors++; $display("FAIL reset_max got=%0d exp=2", max_count); end
        checks++; if (ns_light !== 3'b100) begin errors++; $display("FAIL reset_ns got=%b exp=100", ns_light); end
        checks++; if (ew_light !== 3'b100) begin errors++; $display("FAIL reset_ew got=%b exp=100", ew_light); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
`ifdef TL_PED_WALK_EN
        checks++; if (walk !== 1'b0) begin errors++; $display("FAIL reset_walk got=%b exp=0", walk); end
`endif
    endtask

    task automatic test_sequence();
        int prev;
        ovf_sel = 1'b0;
        apply_reset();
        for (int c = 0; c < 3 * PERIOD + 4; c++) begin
            checks++; if (phase !== 3'(m_ph)) begin errors++; $display("FAIL seq_phase c=%0d got=%0d exp=%0d", c, phase, m_ph); end
            checks++; if (max_count !== 11'(phase_len(m_ph) - 1)) begin errors++; $display("FAIL seq_max c=%0d got=%0d exp=%0d", c, max_count, phase_len(m_ph) - 1); end
            checks++; if (ns_light !== exp_ns(m_ph)) begin errors++; $display("FAIL seq_ns c=%0d got=%b exp=%b", c, ns_light, exp_ns(m_ph)); end
            checks++; if (ew_light !== exp_ew(m_ph)) begin errors++; $display("FAIL seq_ew c=%0d got=%b exp=%b", c, ew_light, exp_ew(m_ph)); end
            checks++; if (fault !== 1'b0) begin errors++; $display("FAIL seq_fault c=%0d got=%b exp=0", c, fault); end
            checks++; if ($countones(ns_light) != 1 || $countones(ew_light) != 1) begin errors++; $display("FAIL seq_onehot c=%0d got=%b/%b exp=one-hot", c, ns_light, ew_light); end
            checks++; if (ns_light !== 3'b100 && ew_light !== 3'b100) begin errors++; $display("FAIL seq_conflict c=%0d got=%b/%b exp=one red", c, ns_light, ew_light); end
`ifdef TL_PED_WALK_EN
            checks++; if (walk !== m_walk) begin errors++; $display("FAIL seq_walk c=%0d got=%b exp=%b", c, walk, m_walk); end
            ped_request = ($urandom_range(0, 15) == 0);
            if (ped_request) m_req = 1;
`endif
            prev = m_ph;
            model_step();
`ifdef TL_PED_WALK_EN
            ped_model(prev);
`endif
            @(negedge clk);
        end
`ifdef TL_PED_WALK_EN
        ped_request = 1'b0;
`endif
    endtask

`ifdef TL_PED_WALK_EN
    task automatic test_walk();
        bit exp_w;
        ovf_sel = 1'b0;
        apply_reset();
        // EW_GREEN occupies cycles 21..28 of each period after reset.
        for (int c = 0; c < 3 * PERIOD; c++) begin
            exp_w = (c >= 21 && c <= 28) || (c >= 21 + 2 * PERIOD && c <= 28 + 2 * PERIOD);
            checks++; if (walk !== exp_w) begin errors++; $display("FAIL walk c=%0d got=%b exp=%b", c, walk, exp_w); end
            ped_request = (c == 6) || (c == 24 + PERIOD);
            @(negedge clk);
        end
        ped_request = 1'b0;
    endtask
`endif

    task automatic test_watchdog();
        ovf_sel = 1'b1;
        ovf_force = 1'b0;
        apply_reset();
        for (int c = 0; c < WDOG; c++) begin
            checks++; if (fault !== 1'b0 || phase !== 3'd0) begin errors++; $display("FAIL wdog_early c=%0d got=%b/%0d exp=0/0", c, fault, phase); end
            @(negedge clk);
        end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wdog_fault got=%b exp=1", fault); end
        checks++; if (phase !== 3'd7) begin errors++; $display("FAIL wdog_phase got=%0d exp=7", phase); end
        checks++; if (ns_light !== 3'b010 || ew_light !== 3'b010) begin errors++; $display("FAIL wdog_lamps got=%b/%b exp=010/010", ns_light, ew_light); end
        for (int c = 0; c < 20; c++) begin
            ovf_force = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (phase !== 3'd7 || fault !== 1'b1) begin errors++; $display("FAIL fault_sticky c=%0d got=%0d/%b exp=7/1", c, phase, fault); end
            checks++; if (max_count !== 11'd2) begin errors++; $display("FAIL fault_max c=%0d got=%0d exp=2", c, max_count); end
        end
        ovf_force = 1'b0;
        ovf_sel = 1'b0;
        apply_reset();
        checks++; if (phase !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL fault_exit got=%0d/%b exp=0/0", phase, fault); end
        checks++; if (ns_light !== 3'b100 || ew_light !== 3'b100) begin errors++; $display("FAIL fault_exit_lamps got=%b/%b exp=100/100", ns_light, ew_light); end
    endtask

    task automatic test_wdog_race();
        ovf_sel = 1'b1;
        ovf_force = 1'b0;
        apply_reset();
        for (int c = 0; c < WDOG - 1; c++) @(negedge clk);
        ovf_force = 1'b1;   // lands on the cycle the watchdog reads WDOG-1
        @(negedge clk);
        ovf_force = 1'b0;
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL race_phase got=%0d exp=1", phase); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL race_fault got=%b exp=0", fault); end
        checks++; if (max_count !== 11'(NS_G - 1)) begin errors++; $display("FAIL race_max got=%0d exp=%0d", max_count, NS_G - 1); end
        checks++; if (ns_light !== 3'b001) begin errors++; $display("FAIL race_ns got=%b exp=001", ns_light); end
        ovf_sel = 1'b0;
    endtask

    task automatic test_midreset();
        int k;
        ovf_sel = 1'b0;
        apply_reset();
        k = int'($urandom_range(21, 28));
        for (int c = 0; c < k; c++) begin
            model_step();
            @(negedge clk);
        end
        checks++; if (phase !== 3'd4 || phase !== 3'(m_ph)) begin errors++; $display("FAIL mid_pre k=%0d got=%0d exp=4", k, phase); end
        resetN = 1'b1;
        @(negedge clk);
        resetN = 1'b0;
        model_reset();
        checks++; if (phase !== 3'd0 || max_count !== 11'd2) begin errors++; $display("FAIL mid_reset got=%0d/%0d exp=0/2", phase, max_count); end
        checks++; if (ns_light !== 3'b100 || ew_light !== 3'b100 || fault !== 1'b0) begin errors++; $display("FAIL mid_reset_out got=%b/%b/%b exp=100/100/0", ns_light, ew_light, fault); end
        for (int c = 0; c < ARED + 3; c++) begin
            checks++; if (phase !== 3'(m_ph)) begin errors++; $display("FAIL mid_restart c=%0d got=%0d exp=%0d", c, phase, m_ph); end
            model_step();
            @(negedge clk);
        end
    endtask

    initial begin
        resetN = 1'b1;
        ovf_sel = 1'b0;
        ovf_force = 1'b0;
`ifdef TL_PED_WALK_EN
        ped_request = 1'b0;
`endif
        test_reset();
        test_sequence();
`ifdef TL_PED_WALK_EN
        test_walk();
`endif
        test_watchdog();
        test_wdog_race();
        for (int i = 0; i < 4; i++) test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
